branch_npc: RTL and testbench

BRANCH_NPC -- requirements
Module: branch_npc

---
 rtl/branch_npc_pkg.sv | 26 ++
 rtl/branch_npc_cmp.sv | 33 +++
 rtl/branch_npc.sv | 125 ++++++++++++
 tb/tb_branch_npc.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/branch_npc_pkg.sv
// Shared definitions for the branch / next-PC block: compare opcodes,
// the fetch reset vector and the redirect FSM state encoding.
package branch_npc_pkg;

    // Branch condition selector as decoded in the D stage
    typedef enum logic [2:0] {
        CMP_BEQ   = 3'd0,
        CMP_BNE   = 3'd1,
        CMP_BLTZ  = 3'd2,
        CMP_BLEZ  = 3'd3,
        CMP_BGTZ  = 3'd4,
        CMP_BGEZ  = 3'd5,
        CMP_ALWAYS = 3'd6,
        CMP_NEVER = 3'd7
    } cmp_op_e;

    // Fetch address taken out of reset
    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    // SEQ: fetching sequentially; PEND: a taken target waits for fetch to accept it
    typedef enum logic {
        ST_SEQ  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/branch_npc_cmp.sv
// Branch condition evaluator: signed 32-bit compares of the forwarded
// register operands, selected by the D-stage compare opcode.
module branch_cmp
    import branch_npc_pkg::*;
(
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [2:0]  cmp_op,
    output logic        cond
);

    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;

    assign rs_s = rs;
    assign rt_s = rt;

    // Pick the condition; the reserved opcode never takes
    always_comb begin
        cond = 1'b0;
        case (cmp_op_e'(cmp_op))
            CMP_BEQ:    cond = (rs_s == rt_s);
            CMP_BNE:    cond = (rs_s != rt_s);
            CMP_BLTZ:   cond = (rs_s <  32'sd0);
            CMP_BLEZ:   cond = (rs_s <= 32'sd0);
            CMP_BGTZ:   cond = (rs_s >  32'sd0);
            CMP_BGEZ:   cond = (rs_s >= 32'sd0);
            CMP_ALWAYS: cond = 1'b1;
            default:    cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_npc.sv
// Next-PC generation with delay-slot semantics. A taken branch resolved
// while fetch is stalled is parked in pend_tgt until fetch can accept it.
// Optional feature: define BRANCH_NPC_STATS_EN to add saturating
// taken / not-taken resolve counters.
module branch_npc
    import branch_npc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_d,
    input  logic        branch,
    input  logic        j,
    input  logic        jal,
    input  logic        jr,
    input  logic [2:0]  cmp_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] ins_d,
    input  logic [31:0] pc_d,
    input  logic        f_stall,
`ifdef BRANCH_NPC_STATS_EN
    output logic [31:0] br_taken_cnt,
    output logic [31:0] br_ntaken_cnt,
`endif
    output logic [31:0] pc_f,
    output logic        taken,
    output logic [31:0] link_addr,
    output logic        redirect_pend
);

    logic        cond;
    logic [31:0] pc_d_plus4;
    logic [31:0] br_offset;
    logic [31:0] target;
    logic [31:0] pend_tgt;
    logic [31:0] pc_next;
    logic [31:0] pend_next;
    state_e      state;
    state_e      state_next;

    // jal only affects write-back, which uses link_addr; target selection
    // treats it like j
    logic unused_jal;
    assign unused_jal = jal;

    branch_cmp u_cmp (
        .rs     (rs_data),
        .rt     (rt_data),
        .cmp_op (cmp_op),
        .cond   (cond)
    );

    assign pc_d_plus4    = pc_d + 32'd4;
    assign link_addr     = pc_d + 32'd8;
    assign br_offset     = {{14{ins_d[15]}}, ins_d[15:0], 2'b00};
    assign taken         = valid_d & branch & cond;
    assign redirect_pend = (state == ST_PEND);

    // Target selection: register jump beats absolute jump beats PC-relative
    always_comb begin
        target = pc_d_plus4 + br_offset;
        if (jr)
            target = rs_data;
        else if (j)
            target = {pc_d_plus4[31:28], ins_d[25:0], 2'b00};
    end

    // Redirect FSM next state, next fetch PC and parked target
    always_comb begin
        state_next = state;
        pc_next    = pc_f;
        pend_next  = pend_tgt;
        case (state)
            ST_SEQ: begin
                if (!f_stall) begin
                    pc_next = taken ? target : pc_f + 32'd4;
                end else if (taken) begin
                    pend_next  = target;
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!f_stall) begin
                    pc_next    = taken ? target : pend_tgt;
                    state_next = ST_SEQ;
                end else if (taken) begin
                    pend_next = target;
                end
            end
            default: state_next = ST_SEQ;
        endcase
    end

    // State, fetch PC and parked target registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_SEQ;
            pc_f     <= PC_RESET;
            pend_tgt <= 32'd0;
        end else begin
            state    <= state_next;
            pc_f     <= pc_next;
            pend_tgt <= pend_next;
        end
    end

`ifdef BRANCH_NPC_STATS_EN
    // Saturating per-outcome resolve counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_taken_cnt  <= 32'd0;
            br_ntaken_cnt <= 32'd0;
        end else if (valid_d && branch) begin
            if (cond) begin
                if (br_taken_cnt != 32'hFFFF_FFFF)
                    br_taken_cnt <= br_taken_cnt + 32'd1;
            end else begin
                if (br_ntaken_cnt != 32'hFFFF_FFFF)
                    br_ntaken_cnt <= br_ntaken_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_npc.sv
// Directed bench for branch_npc; define BRANCH_NPC_STATS_EN to also
// exercise the resolve counters.
module tb_branch_npc;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_d, branch, j, jal, jr, f_stall;
    logic [2:0]  cmp_op;
    logic [31:0] rs_data, rt_data, ins_d, pc_d;
    logic [31:0] pc_f, link_addr;
    logic        taken, redirect_pend;
`ifdef BRANCH_NPC_STATS_EN
    logic [31:0] br_taken_cnt, br_ntaken_cnt;
`endif

    int checks = 0;
    int errors = 0;

    branch_npc dut (
        .clk           (clk),
        .reset         (reset),
        .valid_d       (valid_d),
        .branch        (branch),
        .j             (j),
        .jal           (jal),
        .jr            (jr),
        .cmp_op        (cmp_op),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .ins_d         (ins_d),
        .pc_d          (pc_d),
        .f_stall       (f_stall),
`ifdef BRANCH_NPC_STATS_EN
        .br_taken_cnt  (br_taken_cnt),
        .br_ntaken_cnt (br_ntaken_cnt),
`endif
        .pc_f          (pc_f),
        .taken         (taken),
        .link_addr     (link_addr),
        .redirect_pend (redirect_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        valid_d = 0; branch = 0; j = 0; jal = 0; jr = 0;
        cmp_op = 3'd0; rs_data = 0; rt_data = 0; ins_d = 0; pc_d = 0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] ins, input logic [31:0] pcd,
                         input logic jj, input logic jl, input logic jrr);
        valid_d = 1; branch = 1; cmp_op = op; rs_data = rs; rt_data = rt;
        ins_d = ins; pc_d = pcd; j = jj; jal = jl; jr = jrr;
        #1;
    endtask

    initial begin
        idle();
        f_stall = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        check("reset_pc", pc_f, 32'h3000);
        check("reset_pend", {31'b0, redirect_pend}, 32'd0);
`ifdef BRANCH_NPC_STATS_EN
        check("reset_tcnt", br_taken_cnt, 32'd0);
        check("reset_ncnt", br_ntaken_cnt, 32'd0);
`endif
        tick(); check("seq1", pc_f, 32'h3004);
        tick(); check("seq2", pc_f, 32'h3008);
        tick(); check("seq3", pc_f, 32'h300C);

        // beq taken, offset -1 word -> 0x3010
        drive(3'd0, 5, 5, 32'h0000_FFFF, 32'h3010, 0, 0, 0);
        check("beq_taken", {31'b0, taken}, 32'd1);
        check("beq_link", link_addr, 32'h3018);
        tick(); check("beq_pc", pc_f, 32'h3010);

        drive(3'd0, 5, 6, 32'h0000_FFFF, 32'h3010, 0, 0, 0);
        check("beq_nt", {31'b0, taken}, 32'd0);
        tick(); check("beq_nt_pc", pc_f, 32'h3014);

        drive(3'd2, 32'h8000_0000, 0, 0, 32'h3014, 0, 0, 0);
        check("bltz_neg", {31'b0, taken}, 32'd1);
        drive(3'd4, 0, 0, 0, 32'h3014, 0, 0, 0);
        check("bgtz_zero", {31'b0, taken}, 32'd0);
        drive(3'd7, 3, 3, 0, 32'h3014, 0, 0, 0);
        check("cmp_rsvd", {31'b0, taken}, 32'd0);
        drive(3'd0, 3, 3, 0, 32'h3014, 0, 0, 0);
        valid_d = 0; #1;
        check("valid_low", {31'b0, taken}, 32'd0);
        tick(); check("no_valid_pc", pc_f, 32'h3018);

        // jal to index 0xC10 from 0x3020
        drive(3'd6, 0, 0, 32'h0000_0C10, 32'h3020, 1, 1, 0);
        check("jal_link", link_addr, 32'h3028);
        tick(); check("jal_pc", pc_f, 32'h3040);

        // jr with j also set: jr wins
        drive(3'd6, 32'h4000, 0, 32'h0000_0C10, 32'h3040, 1, 0, 1);
        tick(); check("jr_pc", pc_f, 32'h4000);
        idle();
        tick(); check("after_jr", pc_f, 32'h4004);

        // stalled taken beq: target 0x4004 + 0x40 = 0x4044
        f_stall = 1;
        drive(3'd0, 1, 1, 32'h0000_0010, 32'h4000, 0, 0, 0);
        tick(); idle();
        check("pend1", {31'b0, redirect_pend}, 32'd1);
        check("hold1", pc_f, 32'h4004);
        tick();
        check("pend2", {31'b0, redirect_pend}, 32'd1);
        check("hold2", pc_f, 32'h4004);
        tick();
        check("pend3", {31'b0, redirect_pend}, 32'd1);
        check("hold3", pc_f, 32'h4004);
        f_stall = 0;
        tick();
        check("pend_tgt_pc", pc_f, 32'h4044);
        check("pend_clear", {31'b0, redirect_pend}, 32'd0);
        tick(); check("post_pend", pc_f, 32'h4048);

        // overwrite parked target while still stalled
        f_stall = 1;
        drive(3'd6, 32'h5000, 0, 0, 32'h4048, 0, 0, 1);
        tick();
        drive(3'd6, 32'h6000, 0, 0, 32'h4048, 0, 0, 1);
        tick(); idle();
        check("ovw_hold", pc_f, 32'h4048);
        f_stall = 0;
        tick(); check("ovw_pc", pc_f, 32'h6000);

        // new taken resolve on release beats parked target
        f_stall = 1;
        drive(3'd6, 32'h7000, 0, 0, 32'h6000, 0, 0, 1);
        tick();
        f_stall = 0;
        drive(3'd6, 32'h8000, 0, 0, 32'h6000, 0, 0, 1);
        tick(); idle();
        check("win_pc", pc_f, 32'h8000);
        check("win_pend", {31'b0, redirect_pend}, 32'd0);

        // wrap
        drive(3'd6, 32'hFFFF_FFFC, 0, 0, 32'h8000, 0, 0, 1);
        tick(); idle();
        check("wrap_pre", pc_f, 32'hFFFF_FFFC);
        tick(); check("wrap", pc_f, 32'h0);

        // reset while a redirect is parked
        f_stall = 1;
        drive(3'd6, 32'h9000, 0, 0, 32'h0, 0, 0, 1);
        tick(); idle();
        check("pre_rst_pend", {31'b0, redirect_pend}, 32'd1);
        reset = 1; #1;
        check("rst_mid_pc", pc_f, 32'h3000);
        check("rst_mid_pend", {31'b0, redirect_pend}, 32'd0);
        f_stall = 0;
        tick();
        reset = 0;
        #1;
        check("rst_rel_pc", pc_f, 32'h3000);
        tick(); check("rst_rel_seq", pc_f, 32'h3004);

`ifdef BRANCH_NPC_STATS_EN
        drive(3'd0, 1, 1, 0, 32'h3004, 0, 0, 0);
        tick();
        drive(3'd1, 1, 1, 0, 32'h3008, 0, 0, 0);
        tick();
        drive(3'd6, 32'h100, 0, 0, 32'h3008, 0, 0, 1);
        tick(); idle();
        check("cnt_taken", br_taken_cnt, 32'd2);
        check("cnt_ntaken", br_ntaken_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
